in_debounce: RTL and testbench

- Front-end conditioning stage that produces the clean `IN` level consumed by the TOP/SUB register stage.
- Synchronises an asynchronous raw input into the `CLK` domain, then debounces it with a counter-qualified FSM.
- Emits a stable level plus single-cycle rise and fall strobes, so downstream logic only ever sees glitch-free, synchronous transitions.

---
 rtl/in_cond_pkg.sv | 25 ++
 rtl/in_debounce_chk.sv | 16 +
 rtl/in_sync.sv | 25 ++
 rtl/in_debounce.sv | 130 +++++++++++++
 tb/tb_in_debounce.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/in_cond_pkg.sv
// Shared types and defaults for the input-conditioning front end.
// Holds the debounce state encoding and an elaboration-time width check.
package in_cond_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int DEBOUNCE_DEF    = 1000;
   localparam int CNT_W_DEF       = 16;

   // True when a w-bit counter can represent the value n.
   function automatic bit cnt_fits(input int w, input int n);
      if (w >= 63) begin
         cnt_fits = 1'b1;
      end else begin
         cnt_fits = ((64'd1 << w) > 64'(n));
      end
   endfunction

endpackage

// File: rtl/in_debounce_chk.sv
// Protocol properties of the debounce outputs, kept apart from the design.
module in_debounce_chk (
   input logic CLK,
   input logic RST,
   input logic OUT,
   input logic RISE,
   input logic FALL,
   input logic BUSY
);

   a_excl: assert property (@(posedge CLK) disable iff (!RST) !(RISE && FALL));
   a_rise: assert property (@(posedge CLK) disable iff (!RST) RISE |-> OUT);
   a_fall: assert property (@(posedge CLK) disable iff (!RST) FALL |-> !OUT);
   a_busy: assert property (@(posedge CLK) disable iff (!RST) BUSY |-> !(RISE || FALL));

endmodule

// File: rtl/in_sync.sv
// Plain flop chain bringing an asynchronous level into the i_clk domain.
// Nothing sits between the flops so every stage gets a full period to resolve.
module in_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   // Shift the raw level through the chain; reset clears every stage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/in_debounce.sv
// Synchronise and debounce a raw input into a clean level with rise/fall strobes.
// A candidate level must be seen DEBOUNCE_CYCLES consecutive samples before OUT follows.
module in_debounce
   import in_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic RAW_IN,
   input  logic EN,
   output logic OUT,
   output logic RISE,
   output logic FALL,
   output logic BUSY
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("in_debounce: SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
      $error("in_debounce: DEBOUNCE_CYCLES must be at least 2");
   end
   if (!cnt_fits(CNT_W, DEBOUNCE_CYCLES)) begin : g_bad_cnt
      $error("in_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
   end

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             w_s;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out;
   logic             r_rise;
   logic             r_fall;
   logic             r_busy;

   in_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_d     (RAW_IN),
      .o_q     (w_s)
   );

   // Debounce FSM; outputs are registered alongside the state, and the
   // count never passes CNT_LAST because reaching it always leaves PEND_*.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= STABLE_LO;
         r_cnt   <= CNT_ZERO;
         r_out   <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            STABLE_LO: begin
               if (EN && w_s) begin
                  r_state <= PEND_HI;
                  r_cnt   <= CNT_ONE;
                  r_busy  <= 1'b1;
               end else begin
                  r_cnt  <= CNT_ZERO;
                  r_busy <= 1'b0;
               end
            end
            PEND_HI: begin
               if (!EN || !w_s) begin
                  r_state <= STABLE_LO;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= STABLE_HI;
                  r_cnt   <= CNT_ZERO;
                  r_out   <= 1'b1;
                  r_rise  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            STABLE_HI: begin
               if (EN && !w_s) begin
                  r_state <= PEND_LO;
                  r_cnt   <= CNT_ONE;
                  r_busy  <= 1'b1;
               end else begin
                  r_cnt  <= CNT_ZERO;
                  r_busy <= 1'b0;
               end
            end
            PEND_LO: begin
               if (!EN || w_s) begin
                  r_state <= STABLE_HI;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= STABLE_LO;
                  r_cnt   <= CNT_ZERO;
                  r_out   <= 1'b0;
                  r_fall  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= STABLE_LO;
               r_cnt   <= CNT_ZERO;
               r_out   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign OUT  = r_out;
   assign RISE = r_rise;
   assign FALL = r_fall;
   assign BUSY = r_busy;

endmodule

// File: tb/tb_in_debounce.sv
// Self-checking bench: directed scenarios plus random bouncing input,
// compared each cycle against a run-length model of the debounce rules.
module tb_in_debounce;

   localparam int S = 2;
   localparam int D = 4;

   logic CLK = 1'b0;
   logic RST;
   logic RAW_IN;
   logic EN;
   logic OUT, RISE, FALL, BUSY;

   int n_chk = 0;
   int n_err = 0;

   // model: out level, length of current qualifying run, raw history
   bit m_out, m_rise, m_fall, m_busy;
   int m_run;
   bit rh [S];

   in_debounce #(
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (4)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .RAW_IN (RAW_IN),
      .EN     (EN),
      .OUT    (OUT),
      .RISE   (RISE),
      .FALL   (FALL),
      .BUSY   (BUSY)
   );

   in_debounce_chk u_chk (
      .CLK  (CLK),
      .RST  (RST),
      .OUT  (OUT),
      .RISE (RISE),
      .FALL (FALL),
      .BUSY (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out  = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_busy = 1'b0;
      m_run  = 0;
      for (int i = 0; i < S; i++) rh[i] = 1'b0;
   endtask

   // OUT follows once D consecutive enabled samples differ from it
   task automatic model_edge(input bit raw, input bit en);
      bit s;
      s = rh[S-1];
      for (int i = S - 1; i > 0; i--) rh[i] = rh[i-1];
      rh[0] = raw;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (en && (s != m_out)) begin
         m_run++;
         if (m_run == D) begin
            m_out  = s;
            m_rise = s;
            m_fall = !s;
            m_run  = 0;
         end
      end else begin
         m_run = 0;
      end
      m_busy = (m_run != 0);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out"},  32'(OUT),  32'(m_out));
      chk({tag, ".rise"}, 32'(RISE), 32'(m_rise));
      chk({tag, ".fall"}, 32'(FALL), 32'(m_fall));
      chk({tag, ".busy"}, 32'(BUSY), 32'(m_busy));
   endtask

   task automatic step(input bit raw, input bit en, input string tag);
      RAW_IN = raw;
      EN     = en;
      @(posedge CLK);
      model_edge(raw, en);
      #1;
      check_all(tag);
   endtask

   // called just after a check (posedge+1); reset stays clear of clock edges
   task automatic async_reset(input string tag);
      #2 RST = 1'b0;
      #1;
      chk({tag, ".out"},  32'(OUT),  32'd0);
      chk({tag, ".rise"}, 32'(RISE), 32'd0);
      chk({tag, ".fall"}, 32'(FALL), 32'd0);
      chk({tag, ".busy"}, 32'(BUSY), 32'd0);
      model_reset();
      #1 RST = 1'b1;
   endtask

   initial begin
      int lat;
      int n_rise;
      int n_fall;
      int n_chg;
      bit prev;
      bit lvl;
      int hold;

      RST    = 1'b1;
      RAW_IN = 1'b0;
      EN     = 1'b1;
      model_reset();
      #1 RST = 1'b0;
      #2;
      check_all("reset");
      @(posedge CLK);
      #1;
      check_all("reset_hold");
      #3 RST = 1'b1;

      // clean rise: OUT follows S+D-1 edges after the first edge seeing 1
      lat = 99;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, "rise");
         if (OUT === 1'b1 && lat == 99) lat = i;
      end
      chk("rise_latency", 32'(lat), 32'(S + D - 1));

      // clean fall
      lat = 99;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, "fall");
         if (OUT === 1'b0 && lat == 99) lat = i;
      end
      chk("fall_latency", 32'(lat), 32'(S + D - 1));

      // glitch one sample short of qualifying
      n_rise = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, "glitch");
         if (RISE === 1'b1) n_rise++;
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, "glitch");
         if (RISE === 1'b1) n_rise++;
      end
      chk("glitch_rise", 32'(n_rise), 32'd0);
      chk("glitch_out", 32'(OUT), 32'd0);

      // enable freeze mid-qualification, then full count after re-enable
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, "en_pend");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "en_off");
      chk("en_off_out", 32'(OUT), 32'd0);
      chk("en_off_busy", 32'(BUSY), 32'd0);
      lat = 99;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, "en_on");
         if (OUT === 1'b1 && lat == 99) lat = i;
      end
      chk("en_latency", 32'(lat), 32'(D - 1));

      // async reset while a fall is being qualified
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "pend_lo");
      chk("pend_lo_busy", 32'(BUSY), 32'd1);
      async_reset("async_rst");
      n_fall = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, "post_rst");
         if (FALL === 1'b1) n_fall++;
      end
      chk("post_rst_fall", 32'(n_fall), 32'd0);

      // bounce burst then settle high
      n_rise = 0;
      n_chg  = 0;
      prev   = OUT;
      for (int i = 0; i < 32; i++) begin
         step((i < 20) ? i[0] : 1'b1, 1'b1, "burst");
         if (RISE === 1'b1) n_rise++;
         if (OUT !== prev) n_chg++;
         prev = OUT;
      end
      chk("burst_rise", 32'(n_rise), 32'd1);
      chk("burst_changes", 32'(n_chg), 32'd1);

      // random bouncing levels with occasional disable and reset
      lvl  = 1'b0;
      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            lvl  = $urandom_range(0, 1) != 0;
            hold = $urandom_range(1, 9);
         end
         hold--;
         step(lvl, $urandom_range(0, 9) != 0, "rand");
         if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
